timer_int_ctrl: RTL and testbench

Timer and interrupt-pending controller for the LoongArch CSR file. It owns the TID, TCFG, TVAL and TICLR registers and the timer-interrupt (TI) pending bit, and samples the hardware interrupt pins. It combines these with CRMD.IE and ECFG.LIE and produces the single `has_int` request that the decode stage tags onto the next instruction and the writeback stage turns into an INT exception. CSR writes arrive from writeback already qualified by the writeback valid bit; reads are served combinationally to the writeback read mux.

---
 rtl/timer_int_ctrl_pkg.sv | 50 +++++
 rtl/stable_counter.sv | 18 +
 rtl/timer_int_ctrl.sv | 128 ++++++++++++
 tb/tb_timer_int_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_int_ctrl_pkg.sv
// Shared CSR constants, TCFG layout and helpers for the timer/interrupt block.
package timer_int_ctrl_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CSR_NUM_W = 14;
  localparam int unsigned CNT_W     = 64;
  localparam int unsigned HW_INT_W  = 8;
  localparam int unsigned IS_W      = 13;

  localparam logic [CSR_NUM_W-1:0] CSR_ECFG  = 14'h004;
  localparam logic [CSR_NUM_W-1:0] CSR_ESTAT = 14'h005;
  localparam logic [CSR_NUM_W-1:0] CSR_TID   = 14'h040;
  localparam logic [CSR_NUM_W-1:0] CSR_TCFG  = 14'h041;
  localparam logic [CSR_NUM_W-1:0] CSR_TVAL  = 14'h042;
  localparam logic [CSR_NUM_W-1:0] CSR_TICLR = 14'h044;

  localparam int unsigned TCFG_EN        = 0;
  localparam int unsigned TCFG_PERIOD    = 1;
  localparam int unsigned TCFG_INITV_LSB = 2;
  localparam int unsigned TCFG_INITV_MSB = 31;

  localparam int unsigned IS_TI  = 11;
  localparam int unsigned IS_IPI = 12;

  localparam logic [5:0] ECODE_INT = 6'h00;

  typedef struct packed {
    logic [TCFG_INITV_MSB-TCFG_INITV_LSB:0] initval;
    logic                                   periodic;
    logic                                   en;
  } tcfg_t;

  typedef enum logic {
    TMR_IDLE  = 1'b0,
    TMR_ARMED = 1'b1
  } tmr_state_e;

  // Bit-masked CSR update: only bits set in wmask take the new value.
  function automatic logic [XLEN-1:0] mask_wr(input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] wmask,
                                              input logic [XLEN-1:0] wvalue);
    return (old & ~wmask) | (wvalue & wmask);
  endfunction

  // TVAL load value derived from a TCFG image.
  function automatic logic [XLEN-1:0] tcfg_reload(input tcfg_t cfg);
    return {cfg.initval, 2'b00};
  endfunction

endpackage

// File: rtl/stable_counter.sv
// Free-running 64-bit stable counter; only built when STABLE_COUNTER_EN is defined.
`ifdef STABLE_COUNTER_EN
module stable_counter
  import timer_int_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  output logic [CNT_W-1:0] value
);

  // Wraps from all-ones to zero by natural overflow.
  always_ff @(posedge clk) begin
    if (!resetn) value <= '0;
    else         value <= value + CNT_W'(1);
  end

endmodule
`endif

// File: rtl/timer_int_ctrl.sv
// Timer (TID/TCFG/TVAL/TICLR), TI pending bit and has_int generation.
// STABLE_COUNTER_EN selects a live 64-bit stable counter on cnt_value.
module timer_int_ctrl
  import timer_int_ctrl_pkg::*;
#(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 csr_we,
  input  logic [CSR_NUM_W-1:0] csr_num,
  input  logic [XLEN-1:0]      csr_wmask,
  input  logic [XLEN-1:0]      csr_wvalue,
  input  logic [CSR_NUM_W-1:0] rd_num,
  output logic                 rd_hit,
  output logic [XLEN-1:0]      rd_value,
  input  logic [HW_INT_W-1:0]  hw_int,
  input  logic                 ipi_int,
  input  logic [1:0]           sw_is,
  input  logic                 crmd_ie,
  input  logic [IS_W-1:0]      ecfg_lie,
  output logic [IS_W-1:0]      estat_is,
  output logic                 has_int,
  output logic [CNT_W-1:0]     cnt_value,
  output logic [XLEN-1:0]      cnt_id
);

  tmr_state_e          state_q, state_d;
  tcfg_t               tcfg_q, tcfg_d, tcfg_wr;
  logic [XLEN-1:0]     tval_q, tval_d;
  logic [XLEN-1:0]     tid_q, tid_d;
  logic                ti_q, ti_d;
  logic [HW_INT_W-1:0] hw_is_q;
  logic                has_int_q;

  logic wr_tid, wr_tcfg, wr_ticlr, ti_clr, expire;

  assign wr_tid   = csr_we && (csr_num == CSR_TID);
  assign wr_tcfg  = csr_we && (csr_num == CSR_TCFG);
  assign wr_ticlr = csr_we && (csr_num == CSR_TICLR);
  assign ti_clr   = wr_ticlr && csr_wmask[0] && csr_wvalue[0];
  assign tcfg_wr  = tcfg_t'(mask_wr(XLEN'(tcfg_q), csr_wmask, csr_wvalue));
  assign expire   = (state_q == TMR_ARMED) && tcfg_q.en && (tval_q == '0);

  // Countdown FSM; a TCFG write overrides reload/decrement, TI set beats TI clear.
  always_comb begin
    state_d = state_q;
    tcfg_d  = tcfg_q;
    tval_d  = tval_q;
    tid_d   = tid_q;
    ti_d    = ti_q;

    case (state_q)
      TMR_ARMED: begin
        if (tcfg_q.en) begin
          if (tval_q != '0) begin
            tval_d = tval_q - XLEN'(1);
          end else if (tcfg_q.periodic) begin
            tval_d = tcfg_reload(tcfg_q);
          end else begin
            tval_d  = '1;
            state_d = TMR_IDLE;
          end
        end
      end
      default: ;
    endcase

    if (wr_tcfg) begin
      tcfg_d  = tcfg_wr;
      tval_d  = tcfg_reload(tcfg_wr);
      state_d = tcfg_wr.en ? TMR_ARMED : TMR_IDLE;
    end

    if (wr_tid) tid_d = mask_wr(tid_q, csr_wmask, csr_wvalue);

    if (ti_clr) ti_d = 1'b0;
    if (expire) ti_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= TMR_IDLE;
      tcfg_q    <= '0;
      tval_q    <= '0;
      tid_q     <= TID_RESET;
      ti_q      <= 1'b0;
      hw_is_q   <= '0;
      has_int_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcfg_q    <= tcfg_d;
      tval_q    <= tval_d;
      tid_q     <= tid_d;
      ti_q      <= ti_d;
      hw_is_q   <= hw_int;
      has_int_q <= crmd_ie && ((estat_is & ecfg_lie) != '0);
    end
  end

  assign estat_is = {ipi_int, ti_q, 1'b0, hw_is_q, sw_is};
  assign has_int  = has_int_q;
  assign cnt_id   = tid_q;

  // Combinational read port for the writeback read mux.
  always_comb begin
    rd_hit   = 1'b0;
    rd_value = '0;
    case (rd_num)
      CSR_TID:   begin rd_hit = 1'b1; rd_value = tid_q;         end
      CSR_TCFG:  begin rd_hit = 1'b1; rd_value = XLEN'(tcfg_q); end
      CSR_TVAL:  begin rd_hit = 1'b1; rd_value = tval_q;        end
      CSR_TICLR: begin rd_hit = 1'b1; rd_value = '0;            end
      default: ;
    endcase
  end

`ifdef STABLE_COUNTER_EN
  stable_counter u_stable_counter (
    .clk    (clk),
    .resetn (resetn),
    .value  (cnt_value)
  );
`else
  assign cnt_value = '0;
`endif

endmodule

// File: tb/tb_timer_int_ctrl.sv
// Self-checking bench for timer_int_ctrl: directed test-plan scenarios plus
// randomized traffic against a behavioural model. Honors STABLE_COUNTER_EN.
module tb_timer_int_ctrl;

  localparam logic [31:0] TID_RST = 32'h1234_5678;
  localparam logic [13:0] A_TID = 14'h040, A_TCFG = 14'h041,
                          A_TVAL = 14'h042, A_TICLR = 14'h044;

  logic        clk, resetn, csr_we, rd_hit, ipi_int, crmd_ie, has_int;
  logic [13:0] csr_num, rd_num;
  logic [31:0] csr_wmask, csr_wvalue, rd_value, cnt_id;
  logic [7:0]  hw_int;
  logic [1:0]  sw_is;
  logic [12:0] ecfg_lie, estat_is;
  logic [63:0] cnt_value;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_tid, m_tcfg, m_tval;
  logic        m_armed, m_ti, m_has_int;
  logic [7:0]  m_hw_is;
  logic [63:0] m_cnt;

  timer_int_ctrl #(.TID_RESET(TID_RST)) dut (
    .clk(clk), .resetn(resetn), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .rd_num(rd_num),
    .rd_hit(rd_hit), .rd_value(rd_value), .hw_int(hw_int), .ipi_int(ipi_int),
    .sw_is(sw_is), .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie), .estat_is(estat_is),
    .has_int(has_int), .cnt_value(cnt_value), .cnt_id(cnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input logic [63:0] c);
`ifdef STABLE_COUNTER_EN
    return c;
`else
    return (c & 64'h0);
`endif
  endfunction

  function automatic logic ref_hit(input logic [13:0] num);
    return (num == A_TID) || (num == A_TCFG) || (num == A_TVAL) || (num == A_TICLR);
  endfunction

  function automatic logic [31:0] ref_read(input logic [13:0] num);
    if (num == A_TID)  return m_tid;
    if (num == A_TCFG) return m_tcfg;
    if (num == A_TVAL) return m_tval;
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_tid = TID_RST; m_tcfg = '0; m_tval = '0; m_armed = 1'b0;
    m_ti = 1'b0; m_has_int = 1'b0; m_hw_is = '0; m_cnt = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_next();
    logic [12:0] is_now;
    logic        fire, nh;
    is_now = {ipi_int, m_ti, 1'b0, m_hw_is, sw_is};
    if (!resetn) begin
      model_reset();
    end else begin
      fire = m_armed && m_tcfg[0] && (m_tval == 0);
      nh   = crmd_ie && ((is_now & ecfg_lie) != 0);
      if (csr_we && csr_num == A_TCFG) begin
        m_tcfg  = (m_tcfg & ~csr_wmask) | (csr_wvalue & csr_wmask);
        m_tval  = (m_tcfg >> 2) * 4;
        m_armed = m_tcfg[0];
      end else if (m_armed && m_tcfg[0]) begin
        if (m_tval != 0)     m_tval = m_tval - 1;
        else if (m_tcfg[1])  m_tval = (m_tcfg >> 2) * 4;
        else begin m_tval = 32'hFFFF_FFFF; m_armed = 1'b0; end
      end
      if (csr_we && csr_num == A_TID)
        m_tid = (m_tid & ~csr_wmask) | (csr_wvalue & csr_wmask);
      if (fire) m_ti = 1'b1;
      else if (csr_we && csr_num == A_TICLR && csr_wmask[0] && csr_wvalue[0]) m_ti = 1'b0;
      m_hw_is   = hw_int;
      m_has_int = nh;
      m_cnt     = m_cnt + 1;
    end
  endtask

  // Called at a negedge with inputs set: compare all outputs, then clock once.
  task automatic step();
    #1;
    chk("rd_hit", 64'(rd_hit), 64'(ref_hit(rd_num)));
    chk("rd_value", 64'(rd_value), 64'(ref_read(rd_num)));
    chk("estat_is", 64'(estat_is), 64'({ipi_int, m_ti, 1'b0, m_hw_is, sw_is}));
    chk("has_int", 64'(has_int), 64'(m_has_int));
    chk("cnt_value", cnt_value, exp_cnt(m_cnt));
    chk("cnt_id", 64'(cnt_id), 64'(m_tid));
    model_next();
    @(negedge clk);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
    step();
    csr_we = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; csr_we = 1'b0; csr_num = '0; csr_wmask = '0; csr_wvalue = '0;
    rd_num = A_TVAL; hw_int = '0; ipi_int = 1'b0; sw_is = '0; crmd_ie = 1'b0;
    ecfg_lie = '0;
    @(negedge clk); @(negedge clk);
    model_reset();

    // Reset state
    #1 chk("rst_tval", 64'(rd_value), 64'h0);
    rd_num = A_TCFG; #1 chk("rst_tcfg", 64'(rd_value), 64'h0);
    chk("rst_tid", 64'(cnt_id), 64'(TID_RST));
    chk("rst_is", 64'(estat_is), 64'h0);
    chk("rst_has_int", 64'(has_int), 64'h0);
    resetn = 1'b1; rd_num = A_TVAL;
    step();

    // One-shot: InitVal=4 -> TVAL 16..0, then all-ones, TI one cycle after 0
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0011);
    for (int i = 16; i >= 0; i--) begin
      chk("os_tval", 64'(rd_value), 64'(i));
      chk("os_ti_low", 64'(estat_is[11]), 64'h0);
      step();
    end
    chk("os_ti_set", 64'(estat_is[11]), 64'h1);
    for (int i = 0; i < 4; i++) begin
      chk("os_tval_ff", 64'(rd_value), 64'hFFFF_FFFF);
      step();
    end
    wr(A_TICLR, 32'h1, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("os_no_rearm", 64'(estat_is[11]), 64'h0);
      step();
    end

    // Periodic with enables: InitVal=2 -> period 9; clear/expiry collision at k=26
    crmd_ie = 1'b1; ecfg_lie = 13'h0800;
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
    for (int k = 0; k < 27; k++) begin
      chk("per_tval", 64'(rd_value), 64'(8 - (k % 9)));
      if (k < 9)   chk("per_ti_low", 64'(estat_is[11]), 64'h0);
      if (k == 9)  begin chk("per_ti_set", 64'(estat_is[11]), 64'h1);
                         chk("per_hi_lag", 64'(has_int), 64'h0); end
      if (k == 10) chk("per_has_int", 64'(has_int), 64'h1);
      if (k == 11) chk("per_ti_clr", 64'(estat_is[11]), 64'h0);
      if (k == 12) chk("per_hi_drop", 64'(has_int), 64'h0);
      if (k == 18) chk("per_ti_set2", 64'(estat_is[11]), 64'h1);
      if (k == 26) chk("coll_pre", 64'(estat_is[11]), 64'h0);
      csr_we = (k == 10 || k == 25 || k == 26);
      csr_num = A_TICLR; csr_wmask = 32'h1; csr_wvalue = 32'h1;
      step();
    end
    csr_we = 1'b0;
    chk("coll_ti", 64'(estat_is[11]), 64'h1);

    // TICLR with mask 0 leaves TI alone
    wr(A_TICLR, 32'h0, 32'h1);
    chk("mask0_ti", 64'(estat_is[11]), 64'h1);
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0);
    wr(A_TICLR, 32'h1, 32'h1);
    chk("stop_ti", 64'(estat_is[11]), 64'h0);

    // Hardware interrupt gating: hw_int[3] -> IS[5]
    ecfg_lie = 13'h0020; hw_int = 8'h08;
    step();
    chk("hw_is5", 64'(estat_is[5]), 64'h1);
    chk("hw_lat1", 64'(has_int), 64'h0);
    step();
    chk("hw_lat2", 64'(has_int), 64'h1);
    crmd_ie = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hw_ie_off", 64'(has_int), 64'h0);
      chk("hw_is5_held", 64'(estat_is[5]), 64'h1);
    end
    hw_int = '0; ecfg_lie = '0;

    // Reset mid-count, then counter restarts
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0101);
    step(); step(); step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    rd_num = A_TCFG; #1 chk("rstm_tcfg", 64'(rd_value), 64'h0);
    rd_num = A_TVAL; #1 chk("rstm_tval", 64'(rd_value), 64'h0);
    chk("rstm_ti", 64'(estat_is[11]), 64'h0);
    chk("rstm_has_int", 64'(has_int), 64'h0);
    for (int i = 0; i < 3; i++) begin
      chk("cnt_seq", cnt_value, exp_cnt(64'(i)));
      step();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [2:0] sel;
      resetn    = ($urandom_range(0, 99) != 0);
      csr_we    = ($urandom_range(0, 2) == 0);
      sel       = 3'($urandom_range(0, 4));
      csr_num   = (sel == 0) ? A_TID : (sel == 1) ? A_TCFG : (sel == 2) ? A_TVAL :
                  (sel == 3) ? A_TICLR : 14'($urandom);
      csr_wmask = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
      csr_wvalue = ($urandom_range(0, 2) != 0) ? ($urandom & 32'h3F) : $urandom;
      sel       = 3'($urandom_range(0, 4));
      rd_num    = (sel == 0) ? A_TID : (sel == 1) ? A_TCFG : (sel == 2) ? A_TVAL :
                  (sel == 3) ? A_TICLR : 14'($urandom);
      if ($urandom_range(0, 3) == 0) hw_int = 8'($urandom);
      ipi_int   = ($urandom_range(0, 7) == 0);
      sw_is     = 2'($urandom);
      crmd_ie   = 1'($urandom);
      ecfg_lie  = 13'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
